// File: rtl/partial_product_stage_if.sv
// Operand, adder-tree and product signals of the partial-product stage.
// The slave modport is the stage's view; master is the surrounding datapath.
interface partial_product_stage_if #(
    parameter int EXPONENT   = 4,
    parameter int A_WIDTH    = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int N = 2 ** EXPONENT;

    logic                         in_valid;
    logic                         in_ready;
    logic [A_WIDTH-1:0]           in_a;
    logic [N-1:0]                 in_b;
    logic [N-1:0][DATA_WIDTH-1:0] pp_bus;
    logic [DATA_WIDTH-1:0]        sum_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_product;
    logic                         busy;

    modport master (
        output in_valid, in_a, in_b, sum_in, out_ready,
        input  in_ready, pp_bus, out_valid, out_product, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, sum_in, out_ready,
        output in_ready, pp_bus, out_valid, out_product, busy
    );
endinterface

// File: rtl/partial_product_stage.sv
// Partial-product feeder for the multiplier adder tree. Registers the shifted
// partial products, waits SETTLE_CYCLES extra cycles for the combinational
// tree, then captures its sum and holds it until downstream takes it.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for an operand pair
// SETTLE | pp_bus driven, down-counter running until the tree settles
// HOLD   | product captured, waiting for out_ready
module partial_product_stage #(
    parameter int EXPONENT      = 4,
    parameter int A_WIDTH       = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    partial_product_stage_if.slave  bus
);
    localparam int N = 2 ** EXPONENT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [7:0]                   cnt_q;
    logic [N-1:0][DATA_WIDTH-1:0] pp_q;
    logic [N-1:0][DATA_WIDTH-1:0] pp_d;
    logic [DATA_WIDTH-1:0]        prod_q;
    logic                         accept;
    logic                         settled;

    assign accept  = (state_q == IDLE) && bus.in_valid;
    assign settled = (state_q == SETTLE) && (cnt_q == 8'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SETTLE;
            SETTLE:  if (cnt_q == 8'd0) state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Settle timer: loaded on accept, counts down to terminal count zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (accept) begin
            cnt_q <= 8'(SETTLE_CYCLES);
        end else if ((state_q == SETTLE) && (cnt_q != 8'd0)) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    // Shifted partial products; bits pushed past DATA_WIDTH fall off
    always_comb begin
        pp_d = '0;
        for (int i = 0; i < N; i++) begin
            pp_d[i] = bus.in_b[i] ? (DATA_WIDTH'(bus.in_a) << i) : '0;
        end
    end

    // Partial-product register, stable for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_q <= '0;
        end else if (accept) begin
            pp_q <= pp_d;
        end
    end

    // Product capture once the tree has had its settle time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else if (settled) begin
            prod_q <= bus.sum_in;
        end
    end

    assign bus.pp_bus      = pp_q;
    assign bus.out_product = prod_q;
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_partial_product_stage.sv
// Directed bench for partial_product_stage: three instances with settle
// times 0, 1 and 3 share the stimulus; the bench models the adder tree.
module tb_partial_product_stage;
   localparam int N  = 16;
   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   logic [N-1:0][DW-1:0] exp_pp;
   logic [15:0]          ra;
   logic [15:0]          rb;
   logic [31:0]          rexp;
   logic                 seen;

   partial_product_stage_if bus0 ();
   partial_product_stage_if bus1 ();
   partial_product_stage_if bus3 ();

   partial_product_stage #(.SETTLE_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   partial_product_stage #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   partial_product_stage #(.SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   function automatic logic [DW-1:0] tree_sum(input logic [N-1:0][DW-1:0] pp);
      logic [DW-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) s = s + pp[i];
      return s;
   endfunction

   assign bus0.in_valid = in_valid;  assign bus0.in_a = in_a;  assign bus0.in_b = in_b;
   assign bus0.out_ready = out_ready; assign bus0.sum_in = tree_sum(bus0.pp_bus);
   assign bus1.in_valid = in_valid;  assign bus1.in_a = in_a;  assign bus1.in_b = in_b;
   assign bus1.out_ready = out_ready; assign bus1.sum_in = tree_sum(bus1.pp_bus);
   assign bus3.in_valid = in_valid;  assign bus3.in_a = in_a;  assign bus3.in_b = in_b;
   assign bus3.out_ready = out_ready; assign bus3.sum_in = tree_sum(bus3.pp_bus);

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] expv);
      int lat;
      chk("op_idle", bus1.in_ready, 1'b1);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("op_latency", lat, 2);
      chk("op_product", bus1.out_product, expv);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_out_valid", bus1.out_valid, 1'b0);
      chk("rst_busy", bus1.busy, 1'b0);
      chk("rst_pp_bus", bus1.pp_bus, '0);
      chk("rst_product", bus1.out_product, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", bus1.in_ready, 1'b1);

      in_a = 16'd5; in_b = 16'd6; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("sw0_k0_ov", bus0.out_valid, 1'b0);
      chk("sw_k0_in_ready", bus3.in_ready, 1'b0);
      tick();
      chk("sw0_k1_ov", bus0.out_valid, 1'b1);
      chk("sw0_product", bus0.out_product, 32'd30);
      chk("sw1_k1_ov", bus1.out_valid, 1'b0);
      chk("sw3_k1_ov", bus3.out_valid, 1'b0);
      tick();
      chk("sw0_k2_ov", bus0.out_valid, 1'b0);
      chk("sw1_k2_ov", bus1.out_valid, 1'b1);
      chk("sw1_product", bus1.out_product, 32'd30);
      chk("sw3_k2_ov", bus3.out_valid, 1'b0);
      tick();
      chk("sw1_k3_ov", bus1.out_valid, 1'b0);
      chk("sw3_k3_ov", bus3.out_valid, 1'b0);
      tick();
      chk("sw3_k4_ov", bus3.out_valid, 1'b1);
      chk("sw3_product", bus3.out_product, 32'd30);
      tick();
      chk("sw3_k5_in_ready", bus3.in_ready, 1'b1);

      in_a = 16'd3; in_b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      exp_pp = '0; exp_pp[0] = 32'd3; exp_pp[2] = 32'd12;
      chk("basic_pp_bus", bus1.pp_bus, exp_pp);
      chk("basic_busy", bus1.busy, 1'b1);
      chk("basic_in_ready", bus1.in_ready, 1'b0);
      tick();
      chk("basic_k1_ov", bus1.out_valid, 1'b0);
      tick();
      chk("basic_k2_ov", bus1.out_valid, 1'b1);
      chk("basic_product", bus1.out_product, 32'd15);
      tick();
      chk("basic_k3_ov", bus1.out_valid, 1'b0);
      chk("basic_k3_in_ready", bus1.in_ready, 1'b1);
      chk("basic_k3_busy", bus1.busy, 1'b0);

      run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      run_op(16'h1234, 16'h0000, 32'd0);
      run_op(16'h0000, 16'h00FF, 32'd0);

      in_a = 16'hABCD; in_b = 16'h8001; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      exp_pp = '0; exp_pp[0] = 32'h0000ABCD; exp_pp[15] = 32'h55E68000;
      repeat (2) tick();
      chk("bp_ov", bus1.out_valid, 1'b1);
      in_a = 16'd1; in_b = 16'd1; in_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!bus1.out_valid || bus1.in_ready || bus1.out_product !== 32'h55E72BCD
             || bus1.pp_bus !== exp_pp) seen = 1'b1;
      end
      chk("bp_stall_stable", seen, 1'b0);
      chk("bp_product", bus1.out_product, 32'h55E72BCD);
      chk("bp_pp_bus", bus1.pp_bus, exp_pp);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bp_rel_ov", bus1.out_valid, 1'b0);
      chk("bp_rel_in_ready", bus1.in_ready, 1'b1);
      chk("bp_rel_no_accept", bus1.pp_bus, exp_pp);

      in_a = 16'h0102; in_b = 16'h0003; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      chk("rh_ov", bus1.out_valid, 1'b1);
      chk("rh_product", bus1.out_product, 32'h00000306);
      #2 rst_n = 1'b0;
      #1;
      chk("rh_async_ov", bus1.out_valid, 1'b0);
      chk("rh_async_busy", bus1.busy, 1'b0);
      chk("rh_async_pp", bus1.pp_bus, '0);
      chk("rh_async_product", bus1.out_product, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rh_rel_in_ready", bus1.in_ready, 1'b1);

      in_a = 16'd7; in_b = 16'd9; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ab_busy", bus1.busy, 1'b1);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus1.out_valid) seen = 1'b1;
      end
      chk("ab_no_out_valid", seen, 1'b0);
      run_op(16'd2, 16'd3, 32'd6);

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rexp = {16'd0, ra} * {16'd0, rb};
         run_op(ra, rb, rexp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
